// File: rtl/mips_multicycle_control_pkg.sv
// Shared encodings for the multi-cycle MIPS control unit: opcodes, funct codes,
// ALU control codes and FSM state numbering.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_J     = 6'b000010;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [4:0] ALU_ADD = 5'b00010;
    localparam logic [4:0] ALU_SUB = 5'b00110;
    localparam logic [4:0] ALU_AND = 5'b00000;
    localparam logic [4:0] ALU_OR  = 5'b00001;
    localparam logic [4:0] ALU_SLT = 5'b00111;

    typedef enum logic [1:0] {
        ALUOP_ADD   = 2'b00,
        ALUOP_SUB   = 2'b01,
        ALUOP_FUNCT = 2'b10
    } alu_op_e;

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_RTYPE  = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_e;

    // Only add/sub can signal a meaningful signed overflow.
    function automatic logic funct_is_arith(input logic [5:0] funct);
        return (funct == FN_ADD) || (funct == FN_SUB);
    endfunction

endpackage

// File: rtl/mips_multicycle_control_alu_decoder.sv
// Combinational ALU decoder: aluOp plus R-type funct to an ALU control code,
// with a flag telling whether funct names a supported R-type operation.
module alu_decoder
    import mips_pkg::*;
(
    input  alu_op_e      aluOp,
    input  logic [5:0]   funct,
    output logic [4:0]   aluControl,
    output logic         funct_ok
);

    logic [4:0] funct_code;

    always_comb begin
        funct_code = ALU_ADD;
        funct_ok   = 1'b1;
        case (funct)
            FN_ADD:  funct_code = ALU_ADD;
            FN_SUB:  funct_code = ALU_SUB;
            FN_AND:  funct_code = ALU_AND;
            FN_OR:   funct_code = ALU_OR;
            FN_SLT:  funct_code = ALU_SLT;
            default: funct_ok   = 1'b0;
        endcase
    end

    always_comb begin
        aluControl = ALU_ADD;
        case (aluOp)
            ALUOP_SUB:   aluControl = ALU_SUB;
            ALUOP_FUNCT: aluControl = funct_code;
            default:     aluControl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mips_multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback
// and drives every enable and select of the fpga_mips datapath.
module mips_multicycle_control
    import mips_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       overflow,
    output logic [4:0] aluControl,
    output logic       pcEn,
    output logic       iord,
    output logic       memWrite,
    output logic       irWrite,
    output logic       regDst,
    output logic       memToReg,
    output logic       regWrite,
    output logic       aluSrcA,
    output logic [1:0] aluSrcB,
    output logic [1:0] pcSrc,
    output logic       illegal,
    output logic [3:0] state
);

    state_e  state_q, state_d;
    logic    ovf_q, ovf_d;
    alu_op_e alu_op;
    logic    funct_ok;
    logic    pc_write, branch;
    logic    ir_write, mem_write, reg_write, illegal_raw;

    alu_decoder u_alu_decoder (
        .aluOp      (alu_op),
        .funct      (funct),
        .aluControl (aluControl),
        .funct_ok   (funct_ok)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        ovf_d       = ovf_q;
        alu_op      = ALUOP_ADD;
        pc_write    = 1'b0;
        branch      = 1'b0;
        ir_write    = 1'b0;
        mem_write   = 1'b0;
        reg_write   = 1'b0;
        illegal_raw = 1'b0;
        iord        = 1'b0;
        regDst      = 1'b0;
        memToReg    = 1'b0;
        aluSrcA     = 1'b0;
        aluSrcB     = 2'b00;
        pcSrc       = 2'b00;
        case (state_q)
            S_FETCH: begin
                ir_write = 1'b1;
                pc_write = 1'b1;
                aluSrcB  = 2'b01;
                ovf_d    = 1'b0;
                state_d  = S_DECODE;
            end
            S_DECODE: begin
                aluSrcB = 2'b11;
                case (op)
                    OP_RTYPE:     begin
                        state_d     = funct_ok ? S_RTYPE : S_FETCH;
                        illegal_raw = ~funct_ok;
                    end
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default: begin
                        state_d     = S_FETCH;
                        illegal_raw = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                state_d = (op == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                iord    = 1'b1;
                state_d = S_MEMWB;
            end
            S_MEMWB: begin
                reg_write = 1'b1;
                memToReg  = 1'b1;
                state_d   = S_FETCH;
            end
            S_MEMWR: begin
                iord      = 1'b1;
                mem_write = 1'b1;
                state_d   = S_FETCH;
            end
            S_RTYPE: begin
                aluSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                ovf_d   = overflow & funct_is_arith(funct);
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                regDst    = 1'b1;
                reg_write = ~ovf_q;
                state_d   = S_FETCH;
            end
            S_ADDIEX: begin
                aluSrcA = 1'b1;
                aluSrcB = 2'b10;
                ovf_d   = overflow;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                reg_write = ~ovf_q;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                aluSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                branch  = 1'b1;
                pcSrc   = 2'b01;
                state_d = S_FETCH;
            end
            S_JUMP: begin
                pc_write = 1'b1;
                pcSrc    = 2'b10;
                state_d  = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Write strobes are gated by rst_n so an asserted reset kills them at once.
    assign pcEn     = rst_n & (pc_write | (branch & zero));
    assign irWrite  = rst_n & ir_write;
    assign memWrite = rst_n & mem_write;
    assign regWrite = rst_n & reg_write;
    assign illegal  = rst_n & illegal_raw;
    assign state    = state_q;

endmodule

// File: tb/tb_mips_multicycle_control.sv
// Randomized self-checking bench: an instruction-level model predicts every
// output on every cycle, plus literal checks taken from hand-worked sequences.
module tb_mips_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [5:0] op, funct;
    logic       zero, overflow;
    logic [4:0] aluControl;
    logic       pcEn, iord, memWrite, irWrite, regDst, memToReg, regWrite, aluSrcA, illegal;
    logic [1:0] aluSrcB, pcSrc;
    logic [3:0] state;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [4:0] alu;
        logic       pc_en, iord, mem_write, ir_write, reg_dst, mem_to_reg, reg_write, src_a;
        logic [1:0] src_b, pc_src;
        logic       ill;
        logic [3:0] st;
    } outs_t;

    localparam int K_LW = 0, K_SW = 1, K_RT = 2, K_ADDI = 3, K_BEQ = 4, K_J = 5, K_BAD = 6;

    logic [3:0] tr_st  [8];
    logic [4:0] tr_alu [8];
    logic       tr_rw  [8];
    logic       tr_pc  [8];
    logic       tr_mw  [8];
    logic       tr_ill [8];

    mips_multicycle_control dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct(funct), .zero(zero), .overflow(overflow),
        .aluControl(aluControl), .pcEn(pcEn), .iord(iord), .memWrite(memWrite),
        .irWrite(irWrite), .regDst(regDst), .memToReg(memToReg), .regWrite(regWrite),
        .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .pcSrc(pcSrc), .illegal(illegal), .state(state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int classify(input logic [5:0] o, input logic [5:0] f);
        case (o)
            6'b100011: return K_LW;
            6'b101011: return K_SW;
            6'b000100: return K_BEQ;
            6'b001000: return K_ADDI;
            6'b000010: return K_J;
            6'b000000: return (f == 6'b100000 || f == 6'b100010 || f == 6'b100100 ||
                               f == 6'b100101 || f == 6'b101010) ? K_RT : K_BAD;
            default:   return K_BAD;
        endcase
    endfunction

    function automatic int instr_len(input int kind);
        case (kind)
            K_LW:               return 5;
            K_SW, K_RT, K_ADDI: return 4;
            K_BEQ, K_J:         return 3;
            default:            return 2;
        endcase
    endfunction

    function automatic logic [4:0] alu_for(input logic [5:0] f);
        case (f)
            6'b100010: return 5'b00110;
            6'b100100: return 5'b00000;
            6'b100101: return 5'b00001;
            6'b101010: return 5'b00111;
            default:   return 5'b00010;
        endcase
    endfunction

    // Expected outputs for cycle `step` of an instruction of class `kind`.
    function automatic outs_t model(input int kind, input int step, input logic [5:0] f,
                                    input logic z, input logic ovf);
        outs_t e = '0;
        e.alu = 5'b00010;
        if (step == 0) begin
            e.ir_write = 1; e.pc_en = 1; e.src_b = 2'b01; e.st = 0;
        end else if (step == 1) begin
            e.src_b = 2'b11; e.st = 1; e.ill = (kind == K_BAD);
        end else begin
            case (kind)
                K_LW, K_SW: begin
                    if (step == 2) begin e.st = 2; e.src_a = 1; e.src_b = 2'b10; end
                    else if (kind == K_SW) begin e.st = 5; e.iord = 1; e.mem_write = 1; end
                    else if (step == 3) begin e.st = 3; e.iord = 1; end
                    else begin e.st = 4; e.reg_write = 1; e.mem_to_reg = 1; end
                end
                K_RT: begin
                    if (step == 2) begin e.st = 6; e.src_a = 1; e.alu = alu_for(f); end
                    else begin e.st = 7; e.reg_dst = 1; e.reg_write = ~ovf; end
                end
                K_ADDI: begin
                    if (step == 2) begin e.st = 9; e.src_a = 1; e.src_b = 2'b10; end
                    else begin e.st = 10; e.reg_write = ~ovf; end
                end
                K_BEQ: begin
                    e.st = 8; e.src_a = 1; e.alu = 5'b00110; e.pc_src = 2'b01; e.pc_en = z;
                end
                default: begin
                    e.st = 11; e.pc_en = 1; e.pc_src = 2'b10;
                end
            endcase
        end
        return e;
    endfunction

    task automatic compare(input outs_t e);
        check("state",      state,      e.st);
        check("aluControl", aluControl, e.alu);
        check("pcEn",       pcEn,       e.pc_en);
        check("iord",       iord,       e.iord);
        check("memWrite",   memWrite,   e.mem_write);
        check("irWrite",    irWrite,    e.ir_write);
        check("regDst",     regDst,     e.reg_dst);
        check("memToReg",   memToReg,   e.mem_to_reg);
        check("regWrite",   regWrite,   e.reg_write);
        check("aluSrcA",    aluSrcA,    e.src_a);
        check("aluSrcB",    aluSrcB,    e.src_b);
        check("pcSrc",      pcSrc,      e.pc_src);
        check("illegal",    illegal,    e.ill);
    endtask

    // Entered at posedge+1 with the DUT in FETCH; returns the same way.
    // zmode/omode: -1 random, else the fixed level. stop_at >= 0 returns early.
    task automatic run_instr(input logic [5:0] o, input logic [5:0] f,
                             input int zmode, input int omode, input int stop_at);
        int   kind = classify(o, f);
        int   len  = instr_len(kind);
        logic ovf_m = 1'b0;
        op = o;
        funct = f;
        for (int k = 0; k < len; k++) begin
            if (k == stop_at) return;
            zero     = (zmode < 0) ? 1'($urandom_range(0, 1)) : 1'(zmode);
            overflow = (omode < 0) ? 1'($urandom_range(0, 1)) : 1'(omode);
            #1;
            compare(model(kind, k, f, zero, ovf_m));
            tr_st[k] = state; tr_alu[k] = aluControl; tr_rw[k] = regWrite;
            tr_pc[k] = pcEn;  tr_mw[k] = memWrite;    tr_ill[k] = illegal;
            if (k == 2 && kind == K_RT)   ovf_m = overflow & (f == 6'b100000 || f == 6'b100010);
            if (k == 2 && kind == K_ADDI) ovf_m = overflow;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        logic [5:0] o, f;
        logic [5:0] legal_fn [5];
        legal_fn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
        rst_n = 1'b0; op = '0; funct = '0; zero = 1'b0; overflow = 1'b0;
        #3;
        check("rst_state",   state,      4'd0);
        check("rst_pcEn",    pcEn,       1'b0);
        check("rst_irWrite", irWrite,    1'b0);
        check("rst_aluSrcB", aluSrcB,    2'b01);
        check("rst_alu",     aluControl, 5'b00010);
        @(posedge clk); @(posedge clk); #1;
        rst_n = 1'b1;

        run_instr(6'b100011, 6'b000000, -1, -1, -1);
        check("lw_states",  {tr_st[0], tr_st[1], tr_st[2], tr_st[3], tr_st[4]}, 20'h01234);
        check("lw_regw",    {tr_rw[0], tr_rw[1], tr_rw[2], tr_rw[3], tr_rw[4]}, 5'b00001);
        check("lw_pcen",    {tr_pc[0], tr_pc[1], tr_pc[2], tr_pc[3], tr_pc[4]}, 5'b10000);
        run_instr(6'b000000, 6'b100010, -1, 0, -1);
        check("sub_alu",    tr_alu[2], 5'b00110);
        check("sub_regw",   tr_rw[3], 1'b1);
        run_instr(6'b000000, 6'b100010, -1, 1, -1);
        check("sub_ovf_regw", tr_rw[3], 1'b0);
        run_instr(6'b000100, 6'b000000, 1, -1, -1);
        check("beq_taken",  tr_pc[2], 1'b1);
        run_instr(6'b000100, 6'b000000, 0, -1, -1);
        check("beq_not",    tr_pc[2], 1'b0);
        run_instr(6'b101011, 6'b000000, -1, -1, -1);
        check("sw_memw",    {tr_mw[0], tr_mw[1], tr_mw[2], tr_mw[3]}, 4'b0001);
        run_instr(6'b000010, 6'b000000, -1, -1, -1);
        check("j_state",    tr_st[2], 4'd11);
        run_instr(6'b111111, 6'b000000, -1, -1, -1);
        check("ill_op",     {tr_ill[0], tr_ill[1]}, 2'b01);
        run_instr(6'b000000, 6'b000000, -1, -1, -1);
        check("ill_fn",     {tr_ill[0], tr_ill[1]}, 2'b01);
        run_instr(6'b001000, 6'b000000, -1, 1, -1);
        check("addi_ovf_regw", tr_rw[3], 1'b0);

        // Reset dropped in the middle of MEMRD.
        run_instr(6'b100011, 6'b000000, -1, -1, 3);
        check("pre_rst_state", state, 4'd3);
        rst_n = 1'b0;
        #1;
        check("midrst_state", state,    4'd0);
        check("midrst_regw",  regWrite, 1'b0);
        check("midrst_memw",  memWrite, 1'b0);
        check("midrst_pcen",  pcEn,     1'b0);
        check("midrst_irw",   irWrite,  1'b0);
        @(posedge clk); #1;
        check("midrst_hold_state", state,    4'd0);
        check("midrst_hold_regw",  regWrite, 1'b0);
        rst_n = 1'b1;
        run_instr(6'b100011, 6'b000000, -1, -1, -1);

        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 7))
                0: o = 6'b100011;
                1: o = 6'b101011;
                2, 3: o = 6'b000000;
                4: o = 6'b000100;
                5: o = 6'b001000;
                6: o = 6'b000010;
                default: o = 6'($urandom);
            endcase
            f = 6'($urandom);
            if (o == 6'b000000 && $urandom_range(0, 3) != 0)
                f = legal_fn[$urandom_range(0, 4)];
            run_instr(o, f, -1, -1, -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_control.md
# mips_multicycle_control

Multi-cycle MIPS control unit: the producing end of the ALU's `aluControl`/`zero`/`overflow` interface. Sequences each instruction through fetch, decode, execute, memory and writeback states. Drives all datapath enables and muxes of the `fpga_mips` multi-cycle datapath. Consumes the ALU status flags for branch resolution and overflow suppression.

## Interface
Parameters:
- none. All encodings are fixed in `mips_pkg`.

Ports:
- `clk` in 1: rising-edge clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `op` in 6: instruction opcode from the instruction register (IR).
- `funct` in 6: R-type funct field from the IR.
- `zero` in 1: ALU zero flag.
- `overflow` in 1: ALU signed-overflow flag.
- `aluControl` out 5: ALU operation.
  - ADD 5'b00010, SUB 5'b00110, AND 5'b00000, OR 5'b00001, SLT 5'b00111.
- `pcEn` out 1: PC load enable.
- `iord` out 1: memory address select; 0 = PC, 1 = ALUOut.
- `memWrite` out 1: data memory write.
- `irWrite` out 1: IR load.
- `regDst` out 1: destination register; 0 = rt, 1 = rd.
- `memToReg` out 1: writeback source; 0 = ALUOut, 1 = MDR.
- `regWrite` out 1: register file write.
- `aluSrcA` out 1: ALU A source; 0 = PC, 1 = register A.
- `aluSrcB` out 2: ALU B source; 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `pcSrc` out 2: next-PC source; 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `illegal` out 1: one-cycle pulse for an unsupported op/funct.
- `state` out 4: current state, for debug.

## Operation
- Moore FSM. Outputs decode from the state register only, except `pcEn` = pcWrite | (branch & `zero`).
- Defaults in every state: all enables 0, `aluControl` = ADD, selects 0.
- States and actions:
  - FETCH: `irWrite`=1, pcWrite=1, `aluSrcB`=01. Next state: DECODE.
  - DECODE: `aluSrcB`=11; computes the branch target. Next state from `op`:
    - 000000 → RTYPE, but only if `funct` ∈ {add 100000, sub 100010, and 100100, or 100101, slt 101010}.
    - 100011 or 101011 → MEMADR.
    - 000100 → BRANCH.
    - 001000 → ADDIEX.
    - 000010 → JUMP.
    - Anything else → FETCH, with `illegal`=1 in the cycle that leaves DECODE.
  - MEMADR: `aluSrcA`=1, `aluSrcB`=10. Next: MEMRD for lw, MEMWR for sw.
  - MEMRD: `iord`=1. Next: MEMWB.
  - MEMWB: `regWrite`=1, `memToReg`=1. Next: FETCH.
  - MEMWR: `iord`=1, `memWrite`=1. Next: FETCH.
  - RTYPE: `aluSrcA`=1, `aluControl` decoded from `funct`. Next: ALUWB.
  - ALUWB: `regDst`=1, `regWrite`=1 & ~ovf_q. Next: FETCH.
  - ADDIEX: `aluSrcA`=1, `aluSrcB`=10. Next: ADDIWB.
  - ADDIWB: `regWrite`=1 & ~ovf_q. Next: FETCH.
  - BRANCH: `aluSrcA`=1, `aluControl`=SUB, branch=1, `pcSrc`=01. Next: FETCH.
  - JUMP: pcWrite=1, `pcSrc`=10. Next: FETCH.
- ovf_q is a register:
  - Loads `overflow` at the end of RTYPE (add/sub only; forced 0 for and/or/slt) and ADDIEX.
  - Cleared in FETCH.
- Cycles per instruction: lw 5, sw 4, R-type 4, addi 4, beq 3, j 3, illegal 2.

## Timing
- Asynchronous reset: state → FETCH, ovf_q → 0.
- While `rst_n`=0, `pcEn`, `irWrite`, `memWrite`, `regWrite` and `illegal` are forced to 0. All other outputs take their FETCH values; `state` = 0.
- First FETCH takes effect on the first rising edge after `rst_n` deasserts.
- `op` and `funct` are sampled combinationally in DECODE, MEMADR and RTYPE. They must be stable from IR load until FETCH.
- `zero` is used combinationally in BRANCH, within the same cycle.
- Reset asserted mid-instruction: all pending writes are abandoned immediately; no partial writeback.

## Structure
- `mips_pkg` holds:
  - opcode and funct localparams;
  - the five `aluControl` codes;
  - the 4-bit state encodings FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTYPE=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10, JUMP=11.
- Sub-module `alu_decoder`: combinational; maps aluOp[1:0] + `funct` → `aluControl` and funct_ok.
  - aluOp 00 → ADD, 01 → SUB, 10 → funct-decoded.

## Test plan
- Reset released with `op`=100011 (lw) → states 0,1,2,3,4,0; `regWrite`=1 and `memToReg`=1 only in state 4; `pcEn`=1 only in state 0.
- `op`=000000, `funct`=100010 (sub), `overflow`=0 → `aluControl`=5'b00110 in RTYPE; `regWrite`=1, `regDst`=1 in ALUWB. Repeat with `overflow`=1 → `regWrite`=0 in ALUWB.
- `op`=000100 (beq): `zero`=1 → `pcEn`=1, `pcSrc`=01 in BRANCH; `zero`=0 → `pcEn`=0. Both back in FETCH after 3 cycles.
- `op`=101011 (sw) → `memWrite`=1, `iord`=1 for exactly one cycle (state 5), `regWrite` never 1. `op`=000010 (j) → `pcEn`=1, `pcSrc`=10 in state 11.
- `op`=111111, and separately `op`=0 with `funct`=000000 → `illegal` pulses one cycle leaving DECODE; no enable asserted; FETCH next.
- `rst_n` dropped mid-MEMRD of lw → immediately state=0 and all write enables 0; no MEMWB occurs. After release, normal FETCH.
